// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target endpoint: register map, STATUS bit
// positions, CONTROL field positions and the frame FSM state type.
package spi_target_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_LEVEL   = 2'd3;

   localparam int unsigned ST_RXFE  = 0;
   localparam int unsigned ST_RXFF  = 1;
   localparam int unsigned ST_RXFO  = 2;
   localparam int unsigned ST_TXF   = 3;
   localparam int unsigned ST_TXU   = 4;
   localparam int unsigned ST_ABORT = 5;
   localparam int unsigned ST_BUSY  = 6;

   localparam int unsigned CTRL_WLEN_LSB = 0;
   localparam int unsigned CTRL_WLEN_MSB = 4;
   localparam int unsigned CTRL_EN       = 15;
   localparam int unsigned CTRL_IRQ_EN   = 16;

   typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/spi_target_if.sv
// Avalon-MM register bus plus SPI pins of the SPI target; the CPU/controller side
// uses the master modport, the endpoint uses the slave modport.
interface spi_target_if;
   logic [1:0]  address;
   logic [3:0]  byteenable;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        sclk;
   logic        mosi;
   logic        cs_n;
   logic        miso;

   modport master (
      output address, byteenable, chipselect, read, write, writedata, sclk, mosi, cs_n,
      input  readdata, miso
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata, sclk, mosi, cs_n,
      output readdata, miso
   );
endinterface

// File: rtl/spi_target_rx_fifo.sv
// Synchronous RX FIFO for the SPI target; a push into a full FIFO is accepted only
// when a pop happens on the same clock.
module spi_target_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W-1:0] level
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PTR_W-1:0] cnt_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == PTR_W'(DEPTH));
   assign level   = cnt_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + PTR_W'(do_push) - PTR_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target endpoint with Avalon-MM register aperture and RX FIFO.
// Define SPI_TARGET_IRQ_EN to add the registered irq output and CONTROL.IRQ_EN.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int unsigned RX_DEPTH = 16,
   parameter int unsigned DATA_W   = 32
) (
   input  logic         clk,
   input  logic         reset,
   spi_target_if.slave  bus
`ifdef SPI_TARGET_IRQ_EN
   ,
   output logic         irq
`endif
);
   localparam int unsigned PTR_W = $clog2(RX_DEPTH) + 1;

   logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic       sclk_dly_q, cs_dly_q;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

   state_t            state_q, state_d;
   logic [4:0]        wlen_q, wlen_d, ctrl_wlen_q, ctrl_wlen_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] in_sh_q, in_sh_d, in_next, out_sh_q, out_sh_d, tx_hold_q, tx_hold_d;
   logic              miso_q, miso_d, txf_q, txf_d, txu_q, txu_d, rxfo_q, rxfo_d;
   logic              abort_q, abort_d, ctrl_en_q, ctrl_en_d, rd_dly_q, ctrl_irq_en;
   logic              rd_sel, wr_sel, rd_data, pop, push, word_start;
   logic [4:0]        bit_idx;
   logic [6:0]        status;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic [PTR_W-1:0]  fifo_level;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;
   assign sclk_fall = ~sclk_sync_q[1] & sclk_dly_q;
   assign cs_fall   = ~cs_sync_q[1] & cs_dly_q;
   assign cs_rise   = cs_sync_q[1] & ~cs_dly_q;

   assign rd_sel  = bus.chipselect & bus.read;
   assign wr_sel  = bus.chipselect & bus.write;
   assign rd_data = rd_sel & (bus.address == ADDR_DATA);
   // One pop per read access, taken on the first cycle of the strobe.
   assign pop     = rd_data & ~rd_dly_q;
   assign in_next = {in_sh_q[DATA_W-2:0], mosi_sync_q[1]};
   assign bit_idx = 5'(cnt_q - 6'd1);
   assign bus.miso = miso_q;

   spi_target_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (DATA_W)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (in_next),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      wlen_d      = wlen_q;
      cnt_d       = cnt_q;
      in_sh_d     = in_sh_q;
      out_sh_d    = out_sh_q;
      tx_hold_d   = tx_hold_q;
      miso_d      = miso_q;
      txf_d       = txf_q;
      txu_d       = txu_q;
      rxfo_d      = rxfo_q;
      abort_d     = abort_q;
      ctrl_wlen_d = ctrl_wlen_q;
      ctrl_en_d   = ctrl_en_q;
      push        = 1'b0;
      word_start  = 1'b0;

      if (wr_sel && bus.address == ADDR_STATUS) begin
         if (bus.writedata[ST_RXFO])  rxfo_d  = 1'b0;
         if (bus.writedata[ST_TXU])   txu_d   = 1'b0;
         if (bus.writedata[ST_ABORT]) abort_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (ctrl_en_q && cs_fall) begin
               state_d    = SHIFT;
               word_start = 1'b1;
            end
         end
         SHIFT: begin
            if (!ctrl_en_q) begin
               state_d = IDLE;
               miso_d  = 1'b0;
            end else if (cs_rise) begin
               state_d = IDLE;
               miso_d  = 1'b0;
               if (cnt_q != ({1'b0, wlen_q} + 6'd1)) abort_d = 1'b1;
            end else if (sclk_rise) begin
               in_sh_d = in_next;
               cnt_d   = cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  push       = 1'b1;
                  word_start = 1'b1;
                  if (fifo_full && !pop) rxfo_d = 1'b1;
               end
            end else if (sclk_fall && cnt_q != 6'd0) begin
               miso_d = out_sh_q[bit_idx];
            end
         end
         default: state_d = IDLE;
      endcase

      if (word_start) begin
         wlen_d  = ctrl_wlen_q;
         cnt_d   = {1'b0, ctrl_wlen_q} + 6'd1;
         in_sh_d = '0;
         if (txf_q) begin
            out_sh_d = tx_hold_q;
            txf_d    = 1'b0;
         end else begin
            out_sh_d = '0;
            txu_d    = 1'b1;
         end
         miso_d = out_sh_d[ctrl_wlen_q];
      end

      // A CPU write in the same cycle as a word-start copy refills the holding register.
      if (wr_sel && bus.address == ADDR_DATA) begin
         tx_hold_d = bus.writedata;
         txf_d     = 1'b1;
      end
      if (wr_sel && bus.address == ADDR_CONTROL) begin
         ctrl_wlen_d = bus.writedata[CTRL_WLEN_MSB:CTRL_WLEN_LSB];
         ctrl_en_d   = bus.writedata[CTRL_EN];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b1;
         state_q     <= IDLE;
         wlen_q      <= '0;
         cnt_q       <= '0;
         in_sh_q     <= '0;
         out_sh_q    <= '0;
         tx_hold_q   <= '0;
         miso_q      <= 1'b0;
         txf_q       <= 1'b0;
         txu_q       <= 1'b0;
         rxfo_q      <= 1'b0;
         abort_q     <= 1'b0;
         ctrl_wlen_q <= '0;
         ctrl_en_q   <= 1'b0;
         rd_dly_q    <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
         mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
         cs_sync_q   <= {cs_sync_q[0], bus.cs_n};
         sclk_dly_q  <= sclk_sync_q[1];
         cs_dly_q    <= cs_sync_q[1];
         state_q     <= state_d;
         wlen_q      <= wlen_d;
         cnt_q       <= cnt_d;
         in_sh_q     <= in_sh_d;
         out_sh_q    <= out_sh_d;
         tx_hold_q   <= tx_hold_d;
         miso_q      <= miso_d;
         txf_q       <= txf_d;
         txu_q       <= txu_d;
         rxfo_q      <= rxfo_d;
         abort_q     <= abort_d;
         ctrl_wlen_q <= ctrl_wlen_d;
         ctrl_en_q   <= ctrl_en_d;
         rd_dly_q    <= rd_data;
      end
   end

`ifdef SPI_TARGET_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_irq_en <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         if (wr_sel && bus.address == ADDR_CONTROL) ctrl_irq_en <= bus.writedata[CTRL_IRQ_EN];
         irq_q <= ctrl_irq_en & (~fifo_empty | rxfo_q | txu_q | abort_q);
      end
   end
   assign irq = irq_q;
`else
   assign ctrl_irq_en = 1'b0;
`endif

   always_comb begin
      status           = '0;
      status[ST_RXFE]  = fifo_empty;
      status[ST_RXFF]  = fifo_full;
      status[ST_RXFO]  = rxfo_q;
      status[ST_TXF]   = txf_q;
      status[ST_TXU]   = txu_q;
      status[ST_ABORT] = abort_q;
      status[ST_BUSY]  = (state_q == SHIFT);
   end

   always_comb begin
      bus.readdata = '0;
      if (rd_sel) begin
         case (bus.address)
            ADDR_DATA:    bus.readdata = fifo_rdata;
            ADDR_STATUS:  bus.readdata = 32'(status);
            ADDR_CONTROL: begin
               bus.readdata[CTRL_WLEN_MSB:CTRL_WLEN_LSB] = ctrl_wlen_q;
               bus.readdata[CTRL_EN]                     = ctrl_en_q;
               bus.readdata[CTRL_IRQ_EN]                 = ctrl_irq_en;
            end
            default:      bus.readdata = 32'(fifo_level);
         endcase
      end
   end
endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target: drives SPI frames and register accesses and checks
// them against a word-level model of the RX FIFO, TX holding register and sticky flags.
module tb_spi_target;
   localparam int unsigned RX_DEPTH = 16;
   localparam int unsigned HALF     = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   spi_target_if bus ();
`ifdef SPI_TARGET_IRQ_EN
   logic irq;
`endif

   spi_target #(
      .RX_DEPTH (RX_DEPTH),
      .DATA_W   (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef SPI_TARGET_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [31:0] m_rx [$];
   logic [31:0] f_words [$];
   bit          m_rxfo, m_txu, m_abort, m_txpend;
   logic [31:0] m_txval;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mask(input int nb);
      logic [31:0] one;
      one = 32'd1;
      return (nb >= 32) ? 32'hFFFF_FFFF : ((one << nb) - 32'd1);
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s    = '0;
      s[0] = (m_rx.size() == 0);
      s[1] = (m_rx.size() == RX_DEPTH);
      s[2] = m_rxfo;
      s[3] = m_txpend;
      s[4] = m_txu;
      s[5] = m_abort;
      return s;
   endfunction

   function automatic logic [31:0] m_word_start();
      logic [31:0] v;
      if (m_txpend) begin
         v        = m_txval;
         m_txpend = 1'b0;
      end else begin
         v     = '0;
         m_txu = 1'b1;
      end
      return v;
   endfunction

   function automatic void m_push(input logic [31:0] w);
      if (m_rx.size() < RX_DEPTH) m_rx.push_back(w);
      else m_rxfo = 1'b1;
   endfunction

   function automatic void m_reset();
      m_rx.delete();
      m_rxfo = 0; m_txu = 0; m_abort = 0; m_txpend = 0; m_txval = '0;
   endfunction

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      #1 d = bus.readdata;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      cpu_read(a, d);
      check_eq(tag, d, exp);
   endtask

   task automatic cpu_tx(input logic [31:0] v);
      cpu_write(2'd0, v);
      m_txpend = 1'b1;
      m_txval  = v;
   endtask

   task automatic clear_flags();
      cpu_write(2'd1, 32'h34);
      m_rxfo = 0; m_txu = 0; m_abort = 0;
   endtask

   task automatic drain();
      while (m_rx.size() != 0) check_reg("rx_data", 2'd0, m_rx.pop_front());
      check_reg("status_drained", 2'd1, m_status());
   endtask

   task automatic spi_word(input logic [31:0] w, input int nb, output logic [31:0] m);
      m = '0;
      for (int i = nb - 1; i >= 0; i--) begin
         bus.mosi = w[i];
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b1;
         m = {m[30:0], bus.miso};
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b0;
      end
   endtask

   // Sends every word in f_words (nb bits each), then an optional partial word.
   task automatic spi_frame(input int nb, input int partial);
      logic [31:0] m, e;
      bus.cs_n = 1'b0;
      e = m_word_start();
      repeat (HALF) @(negedge clk);
      foreach (f_words[k]) begin
         spi_word(f_words[k], nb, m);
         check_eq("miso_word", m, e & mask(nb));
         m_push(f_words[k] & mask(nb));
         e = m_word_start();
      end
      if (partial > 0) begin
         spi_word($urandom, partial, m);
         m_abort = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      bus.cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   initial begin
      logic [31:0] m;
      int nb, nw, part;
      bus.address = '0; bus.byteenable = 4'hF; bus.chipselect = 1'b0; bus.read = 1'b0;
      bus.write = 1'b0; bus.writedata = '0; bus.sclk = 1'b0; bus.mosi = 1'b0; bus.cs_n = 1'b1;
      m_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;

      check_eq("reset_miso", {31'b0, bus.miso}, 32'h0);
      check_eq("reset_readdata_idle", bus.readdata, 32'h0);
      check_reg("reset_status", 2'd1, 32'h1);
      check_reg("reset_control", 2'd2, 32'h0);
      check_reg("reset_level", 2'd3, 32'h0);
      check_reg("reset_data", 2'd0, 32'h0);

      // 8-bit word with TX 0xA5.
      cpu_write(2'd2, 32'h0000_8007);
      check_reg("control_rb", 2'd2, 32'h0000_8007);
      cpu_tx(32'hA5);
      check_reg("status_txf", 2'd1, m_status());
      f_words = '{32'h3C};
      spi_frame(8, 0);
      check_eq("idle_miso", {31'b0, bus.miso}, 32'h0);
      check_reg("level_one", 2'd3, 32'd1);
      drain();

      // 32-bit words, second one underruns.
      clear_flags();
      cpu_write(2'd2, 32'h0000_801F);
      cpu_tx(32'hC3A5_F00F);
      f_words = '{32'hDEAD_BEEF, 32'h1234_5678};
      spi_frame(32, 0);
      check_reg("status_txu", 2'd1, m_status());
      check_reg("level_two", 2'd3, 32'd2);
      drain();

      // Overflow: 17 words without reads.
      clear_flags();
      cpu_write(2'd2, 32'h0000_8007);
      f_words.delete();
      for (int i = 0; i < 17; i++) f_words.push_back($urandom_range(0, 255));
      spi_frame(8, 0);
      check_reg("level_full", 2'd3, 32'd16);
      check_reg("status_ovf", 2'd1, m_status());
      cpu_write(2'd1, 32'h4);
      m_rxfo = 1'b0;
      check_reg("status_rxfo_clr", 2'd1, m_status());
      drain();

      // Abort after 5 of 8 bits, then a good frame.
      clear_flags();
      f_words.delete();
      spi_frame(8, 5);
      check_reg("level_abort", 2'd3, 32'd0);
      check_reg("status_abort", 2'd1, m_status());
      f_words = '{32'(($urandom_range(0, 255)))};
      spi_frame(8, 0);
      drain();

      // Reset mid-word, then a fresh frame.
      bus.cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_word(32'hFF, 3, m);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_reset();
      repeat (HALF) @(negedge clk);
      bus.cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      check_reg("level_after_reset", 2'd3, 32'd0);
      check_reg("status_after_reset", 2'd1, m_status());
      cpu_write(2'd2, 32'h0000_8007);
      f_words = '{32'h81};
      spi_frame(8, 0);
      check_reg("level_post_reset", 2'd3, 32'd1);
      drain();

      // Randomized frames.
      for (int it = 0; it < 8; it++) begin
         clear_flags();
         nb = $urandom_range(1, 32);
         nw = $urandom_range(1, 3);
         cpu_write(2'd2, 32'h8000 | 32'(nb - 1));
         if ($urandom_range(0, 1) == 1) cpu_tx($urandom);
         f_words.delete();
         for (int k = 0; k < nw; k++) f_words.push_back($urandom);
         part = (nb > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, nb - 1) : 0;
         spi_frame(nb, part);
         check_reg("rand_level", 2'd3, 32'(m_rx.size()));
         check_reg("rand_status", 2'd1, m_status());
         drain();
      end

`ifdef SPI_TARGET_IRQ_EN
      clear_flags();
      cpu_write(2'd2, 32'h0001_8007);
      repeat (2) @(negedge clk);
      check_eq("irq_idle", {31'b0, irq}, 32'h0);
      f_words = '{32'h5A};
      spi_frame(8, 0);
      check_eq("irq_word", {31'b0, irq}, 32'h1);
      drain();
      clear_flags();
      repeat (2) @(negedge clk);
      check_eq("irq_cleared", {31'b0, irq}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
